// File: rtl/alu_exec_unit_pkg.sv
// ---------------------------------------------------------------------------
// alu_exec_unit_pkg
//   Shared definitions for the execute stage: ALUOp encodings, funct field
//   codes, internal 4-bit ALU control codes, FSM states and the decode helper
//   that maps {alu_op, funct} onto an ALU control code or a mult/div request.
// ---------------------------------------------------------------------------
package alu_exec_unit_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    // ALU_NONE covers unknown funct codes and mult/div requests: the
    // single-cycle ALU produces 0 for them.
    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLTU = 4'b1000,
        ALU_XOR  = 4'b1001,
        ALU_NOR  = 4'b1100,
        ALU_MFHI = 4'b1101,
        ALU_MFLO = 4'b1110,
        ALU_NONE = 4'b1111
    } alu_ctl_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIN  = 2'b11
    } state_e;

    typedef struct packed {
        alu_ctl_e ctl;
        logic     is_md;
        logic     md_div;
        logic     md_signed;
    } dec_t;

    function automatic dec_t decode(input logic [1:0] alu_op, input logic [5:0] funct);
        dec_t d;
        d.ctl       = ALU_ADD;
        d.is_md     = 1'b0;
        d.md_div    = 1'b0;
        d.md_signed = 1'b0;
        case (alu_op)
            ALUOP_ADD, ALUOP_RSVD: d.ctl = ALU_ADD;
            ALUOP_SUB:             d.ctl = ALU_SUB;
            ALUOP_RTYPE: begin
                d.ctl = ALU_NONE;
                case (funct)
                    FUNCT_ADD, FUNCT_ADDU: d.ctl = ALU_ADD;
                    FUNCT_SUB, FUNCT_SUBU: d.ctl = ALU_SUB;
                    FUNCT_AND:   d.ctl = ALU_AND;
                    FUNCT_OR:    d.ctl = ALU_OR;
                    FUNCT_XOR:   d.ctl = ALU_XOR;
                    FUNCT_NOR:   d.ctl = ALU_NOR;
                    FUNCT_SLT:   d.ctl = ALU_SLT;
                    FUNCT_SLTU:  d.ctl = ALU_SLTU;
                    FUNCT_MFHI:  d.ctl = ALU_MFHI;
                    FUNCT_MFLO:  d.ctl = ALU_MFLO;
                    FUNCT_MULT:  begin d.is_md = 1'b1; d.md_signed = 1'b1; end
                    FUNCT_MULTU: begin d.is_md = 1'b1; end
                    FUNCT_DIV:   begin d.is_md = 1'b1; d.md_div = 1'b1; d.md_signed = 1'b1; end
                    FUNCT_DIVU:  begin d.is_md = 1'b1; d.md_div = 1'b1; end
                    default:     d.ctl = ALU_NONE;
                endcase
            end
            default: d.ctl = ALU_ADD;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// ---------------------------------------------------------------------------
// alu_exec_unit_if
//   Operand/result bus of the execute stage.
//   Input side : in_valid/in_ready handshake, funct, alu_op, data1, data2.
//   Output side: out_valid/out_ready handshake, result, zero, busy.
//   slave  modport: the execute unit.   master modport: the pipeline driving it.
// ---------------------------------------------------------------------------
interface alu_exec_unit_if #(parameter int WIDTH = 32) ();
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       funct;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;

    modport slave (
        input  in_valid, funct, alu_op, data1, data2, out_ready,
        output in_ready, out_valid, result, zero, busy
    );

    modport master (
        output in_valid, funct, alu_op, data1, data2, out_ready,
        input  in_ready, out_valid, result, zero, busy
    );
endinterface

// File: rtl/alu_exec_unit_muldiv_iter.sv
// ---------------------------------------------------------------------------
// alu_muldiv_iter
//   Iterative multiplier / restoring divider, one bit per cycle, WIDTH steps.
//   Works on operand magnitudes; signs are reapplied on the hi/lo outputs.
//   Ports: clk, rst_n (sync, active-low), start (latch operands, clear count),
//          run (iterate while counter < WIDTH), is_signed, is_div, a, b,
//          done (counter == WIDTH), hi, lo (final HI/LO values once done).
// ---------------------------------------------------------------------------
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             run,
    input  logic             is_signed,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] work_q, work_d;   // mult: {acc, multiplier}; div: {rem, quotient}
    logic [WIDTH-1:0]   mag_q, mag_d;     // |b|: addend for mult, divisor for div
    logic [WIDTH-1:0]   opa_q, opa_d;     // raw dividend, returned as HI on divide by zero
    logic               div_q, div_d;
    logic               dz_q, dz_d;
    logic               negq_q, negq_d;   // negate product / quotient
    logic               negr_q, negr_d;   // negate remainder

    logic [WIDTH:0]     rem_sh, diff, sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   qmag, rmag;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    assign done = (cnt_q == CNT_W'(WIDTH));

    always_comb begin
        cnt_d  = cnt_q;
        work_d = work_q;
        mag_d  = mag_q;
        opa_d  = opa_q;
        div_d  = div_q;
        dz_d   = dz_q;
        negq_d = negq_q;
        negr_d = negr_q;
        rem_sh = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, mag_q};
        sum    = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, (work_q[0] ? mag_q : '0)};
        if (start) begin
            cnt_d  = '0;
            work_d = {{WIDTH{1'b0}}, magnitude(a, is_signed)};
            mag_d  = magnitude(b, is_signed);
            opa_d  = a;
            div_d  = is_div;
            dz_d   = (b == '0);
            negq_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            negr_d = is_signed && a[WIDTH-1];
        end else if (run && !done) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (div_q) begin
                // Restoring step: shift next dividend bit into the remainder,
                // keep the subtraction only when it does not go negative.
                if (!diff[WIDTH])
                    work_d = {diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
                else
                    work_d = {rem_sh[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
            end else begin
                // Shift-add: conditionally add, then shift the whole pair right.
                work_d = {sum, work_q[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        prod = negq_q ? -work_q : work_q;
        qmag = work_q[WIDTH-1:0];
        rmag = work_q[2*WIDTH-1:WIDTH];
        if (div_q) begin
            lo = dz_q ? '1    : (negq_q ? -qmag : qmag);
            hi = dz_q ? opa_q : (negr_q ? -rmag : rmag);
        end else begin
            lo = prod[WIDTH-1:0];
            hi = prod[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    always_ff @(posedge clk) begin
        work_q <= work_d;
        mag_q  <= mag_d;
        opa_q  <= opa_d;
        div_q  <= div_d;
        dz_q   <= dz_d;
        negq_q <= negq_d;
        negr_q <= negr_d;
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//   Execute stage: ALU control decode, single-cycle ALU with registered
//   output, iterative mult/div with HI/LO, valid/ready backpressure.
//   Ports: clk, rst_n (sync, active-low), bus (alu_exec_unit_if.slave):
//          in_valid/in_ready, funct, alu_op, data1, data2 in;
//          out_valid/out_ready, result, zero, busy out.
// ---------------------------------------------------------------------------
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_exec_unit_if.slave bus
);
    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    dec_t                    dec;
    logic                    in_ready, accept;
    logic                    md_start, md_run, md_done;
    logic [WIDTH-1:0]        md_hi, md_lo;
    logic [WIDTH-1:0]        alu_y;
    logic signed [WIDTH-1:0] op_a, op_b;

    assign dec      = decode(bus.alu_op, bus.funct);
    assign op_a     = bus.data1;
    assign op_b     = bus.data2;
    // A new beat may enter in the same cycle the held result is consumed.
    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign md_run   = (state_q == ST_MUL) || (state_q == ST_DIV);

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (md_start),
        .run       (md_run),
        .is_signed (dec.md_signed),
        .is_div    (dec.md_div),
        .a         (bus.data1),
        .b         (bus.data2),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo)
    );

    always_comb begin
        alu_y = '0;
        case (dec.ctl)
            ALU_AND:  alu_y = bus.data1 & bus.data2;
            ALU_OR:   alu_y = bus.data1 | bus.data2;
            ALU_ADD:  alu_y = bus.data1 + bus.data2;
            ALU_SUB:  alu_y = bus.data1 - bus.data2;
            ALU_SLT:  alu_y[0] = (op_a < op_b);
            ALU_SLTU: alu_y[0] = (bus.data1 < bus.data2);
            ALU_XOR:  alu_y = bus.data1 ^ bus.data2;
            ALU_NOR:  alu_y = ~(bus.data1 | bus.data2);
            ALU_MFHI: alu_y = hi_q;
            ALU_MFLO: alu_y = lo_q;
            default:  alu_y = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        result_d    = result_q;
        zero_d      = zero_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        md_start    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (dec.is_md) begin
                        md_start = 1'b1;
                        state_d  = dec.md_div ? ST_DIV : ST_MUL;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_y;
                        zero_d      = (alu_y == '0);
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (md_done) state_d = ST_FIN;
            end
            ST_FIN: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b1;
                result_d    = md_lo;
                zero_d      = (md_lo == '0);
                hi_d        = md_hi;
                lo_d        = md_lo;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//   Directed and randomized stimulus for alu_exec_unit (WIDTH=32) checked
//   against an arithmetic reference model and an in-order scoreboard.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;
    localparam int W = 32;

    localparam logic [5:0] F_ADD = 6'b100000, F_ADDU = 6'b100001, F_SUB = 6'b100010,
                           F_SUBU = 6'b100011, F_AND = 6'b100100, F_OR = 6'b100101,
                           F_XOR = 6'b100110, F_NOR = 6'b100111, F_SLT = 6'b101010,
                           F_SLTU = 6'b101011, F_MFHI = 6'b010000, F_MFLO = 6'b010010,
                           F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010,
                           F_DIVU = 6'b011011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_exec_unit_if #(.WIDTH(W)) bus ();
    alu_exec_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_hi, m_lo;
    logic [31:0] exp_q[$];
    int          hold_left = 0;
    int          rdy_pct = 100;
    bit          last_acc;
    bit          prev_hold = 0;
    logic [31:0] prev_res;
    logic        prev_zero;
    logic [5:0]  f_list[16] = '{F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
                                F_SLT, F_SLTU, F_MFHI, F_MFLO, F_MULT, F_MULTU, F_DIV, F_DIVU};

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: plain arithmetic on 32/64-bit values.
    task automatic model_op(input logic [1:0] op, input logic [5:0] f,
                            input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] r);
        logic [63:0] p;
        int sa, sb;
        sa = a;
        sb = b;
        r = 32'h0;
        if (op != 2'b10) begin
            r = (op == 2'b01) ? a - b : a + b;
        end else begin
            case (f)
                F_ADD, F_ADDU: r = a + b;
                F_SUB, F_SUBU: r = a - b;
                F_AND:  r = a & b;
                F_OR:   r = a | b;
                F_XOR:  r = a ^ b;
                F_NOR:  r = ~(a | b);
                F_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
                F_SLTU: r = (a < b) ? 32'd1 : 32'd0;
                F_MFHI: r = m_hi;
                F_MFLO: r = m_lo;
                F_MULT, F_MULTU: begin
                    if (f == F_MULT) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                    else             p = {32'h0, a} * {32'h0, b};
                    m_hi = p[63:32];
                    m_lo = p[31:0];
                    r = m_lo;
                end
                F_DIV, F_DIVU: begin
                    if (b == 32'h0) begin
                        m_lo = 32'hFFFF_FFFF;
                        m_hi = a;
                    end else if (f == F_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        m_lo = 32'h8000_0000;
                        m_hi = 32'h0;
                    end else if (f == F_DIV) begin
                        m_lo = sa / sb;
                        m_hi = sa % sb;
                    end else begin
                        m_lo = a / b;
                        m_hi = a % b;
                    end
                    r = m_lo;
                end
                default: r = 32'h0;
            endcase
        end
    endtask

    // One clock: choose out_ready, observe both handshakes at the falling
    // edge, then step to just past the next rising edge.
    task automatic tick();
        logic [31:0] e;
        if (hold_left > 0) begin
            bus.out_ready = 1'b0;
            hold_left--;
        end else begin
            bus.out_ready = ($urandom_range(99) < rdy_pct);
        end
        @(negedge clk);
        if (prev_hold) begin
            check_val("hold_valid", bus.out_valid, 1);
            check_val("hold_result", bus.result, prev_res);
            check_val("hold_zero", bus.zero, prev_zero);
        end
        if (bus.out_valid && bus.out_ready) begin
            check_val("beat_expected", {63'h0, exp_q.size() != 0}, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_val("result", bus.result, e);
                check_val("zero", bus.zero, e == 32'h0);
            end
        end
        last_acc = bus.in_valid && bus.in_ready;
        if (last_acc) begin
            model_op(bus.alu_op, bus.funct, bus.data1, bus.data2, e);
            exp_q.push_back(e);
        end
        prev_hold = bus.out_valid && !bus.out_ready;
        prev_res  = bus.result;
        prev_zero = bus.zero;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b, output int waits);
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.funct    = f;
        bus.data1    = a;
        bus.data2    = b;
        waits = 0;
        do begin
            tick();
            if (!last_acc) waits++;
        end while (!last_acc && waits <= 200);
        if (!last_acc) check_val("accept_timeout", 64'(waits), 64'd0);
        bus.in_valid = 1'b0;
        bus.data1    = $urandom;
        bus.data2    = $urandom;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'(int'($urandom_range(20)) - 10);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed %0d vectors", n_vec);
        $fatal(1);
    end

    initial begin
        int w;
        int stray;
        logic [1:0] op;
        logic [5:0] f;
        logic [31:0] a, b;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.alu_op    = 2'b00;
        bus.funct     = 6'h0;
        bus.data1     = 32'h0;
        bus.data2     = 32'h0;
        m_hi = 32'h0;
        m_lo = 32'h0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_result", bus.result, 0);
        check_val("rst_zero", bus.zero, 1);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Directed single-cycle ops
        send(2'b10, F_ADD, 32'hFFFF_FFFF, 32'h1, w);
        check_val("lat1_valid", bus.out_valid, 1);
        check_val("lat1_zero", bus.zero, 1);
        send(2'b10, F_SLT, 32'hFFFF_FFFE, 32'h1, w);
        send(2'b10, F_SLTU, 32'hFFFF_FFFE, 32'h1, w);
        send(2'b10, F_NOR, 32'h0F0F_0000, 32'h0000_00FF, w);
        send(2'b11, 6'h3F, 32'd40, 32'd2, w);
        send(2'b01, 6'h3F, 32'd5, 32'd9, w);

        // Multiply then HI/LO reads stall until the result is written
        send(2'b10, F_MULT, 32'hFFFF_FFFD, 32'd7, w);
        check_val("mult_busy", bus.busy, 1);
        send(2'b10, F_MFHI, 32'h0, 32'h0, w);
        check_val("mult_stall_cycles", 64'(w), 64'd34);
        send(2'b10, F_MFLO, 32'h0, 32'h0, w);

        send(2'b10, F_DIV, 32'hFFFF_FFF9, 32'd2, w);
        send(2'b10, F_MFHI, 32'h0, 32'h0, w);
        send(2'b10, F_DIVU, 32'd5, 32'd0, w);
        send(2'b10, F_MFHI, 32'h0, 32'h0, w);
        send(2'b10, F_MFLO, 32'h0, 32'h0, w);
        send(2'b10, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, w);
        send(2'b10, F_MFHI, 32'h0, 32'h0, w);
        send(2'b10, F_DIV, 32'hFFFF_FFF0, 32'h0, w);
        send(2'b10, F_MFHI, 32'h0, 32'h0, w);

        // Backpressure: result held, next beat taken the cycle it drains
        send(2'b10, F_XOR, 32'h1234_5678, 32'h0F0F_0F0F, w);
        hold_left = 5;
        send(2'b10, F_SUB, 32'd3, 32'd3, w);
        check_val("bp_accept_cycle", 64'(w), 64'd5);

        // Reset in the middle of a multiply
        send(2'b10, F_MULTU, 32'hDEAD_BEEF, 32'h1234_5678, w);
        repeat (9) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        m_hi = 32'h0;
        m_lo = 32'h0;
        prev_hold = 0;
        @(negedge clk);
        check_val("mid_rst_out_valid", bus.out_valid, 0);
        check_val("mid_rst_busy", bus.busy, 0);
        check_val("mid_rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        stray = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.out_valid) stray++;
        end
        check_val("mid_rst_stray_beats", 64'(stray), 64'd0);
        send(2'b10, F_MFHI, 32'h0, 32'h0, w);
        send(2'b10, F_MFLO, 32'h0, 32'h0, w);

        // Randomized traffic with random backpressure
        rdy_pct = 70;
        for (int n = 0; n < 400; n++) begin
            op = ($urandom_range(9) < 7) ? 2'b10 : 2'($urandom_range(3));
            f  = ($urandom_range(15) == 0) ? 6'($urandom_range(63)) : f_list[$urandom_range(15)];
            a  = rnd_val();
            b  = rnd_val();
            send(op, f, a, b, w);
            repeat ($urandom_range(2)) tick();
        end

        rdy_pct = 100;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        check_val("drain_depth", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
